// File: rtl/trdb_pkg.sv
// Shared trace-debugger constants: branch map depth and the matching count width.
package trdb_pkg;

    localparam int unsigned BRANCH_MAP_LEN   = 31;
    localparam int unsigned BRANCH_COUNT_LEN = $clog2(BRANCH_MAP_LEN + 1);

endpackage

// File: rtl/trdb_branch_map.sv
// Accumulates resolved branch outcomes (1 = not taken) LSB-first until the packet
// emitter flushes the map; branches arriving while full are dropped and flagged.
module trdb_branch_map
    import trdb_pkg::*;
#(
    parameter int unsigned MAP_LEN = BRANCH_MAP_LEN
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             valid_i,
    input  logic                             taken_i,
    input  logic                             flush_i,
    output logic [MAP_LEN-1:0]               map_o,
    output logic [$clog2(MAP_LEN+1)-1:0]     branches_o,
    output logic                             full_o,
    output logic                             empty_o,
    output logic                             overflow_o
);

    localparam int unsigned CNT_W = (MAP_LEN == BRANCH_MAP_LEN) ? BRANCH_COUNT_LEN
                                                                : $clog2(MAP_LEN + 1);

    logic [MAP_LEN-1:0] map_q, map_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               full;

    assign full = (cnt_q == CNT_W'(MAP_LEN));

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path infers a latch.
        map_d = map_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (flush_i) begin
            // The flush consumes the old map; a coincident branch starts the new one.
            map_d = '0;
            map_d[0] = valid_i & ~taken_i;
            cnt_d = valid_i ? CNT_W'(1) : '0;
            ovf_d = 1'b0;
        end else if (valid_i) begin
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                map_d[cnt_q] = ~taken_i;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            map_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            map_q <= map_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign map_o      = map_q;
    assign branches_o = cnt_q;
    assign full_o     = full;
    assign empty_o    = (cnt_q == '0);
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_trdb_branch_map.sv
// Directed and random checks of trdb_branch_map against a queue-of-outcomes model.
module tb_trdb_branch_map;

    localparam int MAP_LEN = 31;

    typedef struct {
        logic [MAP_LEN-1:0] map;
        logic [4:0]         cnt;
        logic               ovf;
    } exp_t;

    logic               clk_i = 1'b0;
    logic               rst_ni = 1'b0;
    logic               valid_i = 1'b0;
    logic               taken_i = 1'b0;
    logic               flush_i = 1'b0;
    logic [MAP_LEN-1:0] map_o;
    logic [4:0]         branches_o;
    logic               full_o;
    logic               empty_o;
    logic               overflow_o;

    int   total = 0;
    int   bad   = 0;
    bit   mq[$];
    bit   movf  = 1'b0;
    exp_t exp_q[$];

    trdb_branch_map #(.MAP_LEN(MAP_LEN)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .valid_i    (valid_i),
        .taken_i    (taken_i),
        .flush_i    (flush_i),
        .map_o      (map_o),
        .branches_o (branches_o),
        .full_o     (full_o),
        .empty_o    (empty_o),
        .overflow_o (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model_now();
        exp_t e;
        e.map = '0;
        foreach (mq[i]) e.map[i] = mq[i];
        e.cnt = 5'(mq.size());
        e.ovf = movf;
        return e;
    endfunction

    task automatic check_outputs(input string tag, input exp_t e);
        check({tag, ".map"},   64'(map_o),      64'(e.map));
        check({tag, ".cnt"},   64'(branches_o), 64'(e.cnt));
        check({tag, ".full"},  64'(full_o),     64'(e.cnt == 5'(MAP_LEN)));
        check({tag, ".empty"}, 64'(empty_o),    64'(e.cnt == 5'd0));
        check({tag, ".ovf"},   64'(overflow_o), 64'(e.ovf));
    endtask

    // Drive one cycle, verify the pre-edge view, then verify the registered result.
    task automatic step(input string tag, input logic v, input logic t, input logic f);
        exp_t e;
        logic [MAP_LEN-1:0] above;
        @(negedge clk_i);
        valid_i = v;
        taken_i = t;
        flush_i = f;
        #1;
        check_outputs({tag, ".pre"}, model_now());
        if (f) begin
            mq.delete();
            movf = 1'b0;
            if (v) mq.push_back(~t);
        end else if (v) begin
            if (mq.size() == MAP_LEN) movf = 1'b1;
            else mq.push_back(~t);
        end
        exp_q.push_back(model_now());
        @(posedge clk_i);
        #1;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
        end else begin
            e = exp_q.pop_front();
            check_outputs(tag, e);
        end
        above = map_o & ~((MAP_LEN'(1) << branches_o) - MAP_LEN'(1));
        check({tag, ".above"}, 64'(above), 64'(0));
    endtask

    initial begin
        // Reset state
        #1;
        check_outputs("reset", model_now());
        @(negedge clk_i);
        rst_ni = 1'b1;

        // taken, not-taken, not-taken -> 3'b110, count 3
        step("s30a", 1'b1, 1'b1, 1'b0);
        step("s30b", 1'b1, 1'b0, 1'b0);
        step("s30c", 1'b1, 1'b0, 1'b0);
        check("s30.map3", 64'(map_o[2:0]), 64'(3'b110));
        check("s30.cnt3", 64'(branches_o), 64'(3));

        // Hold with no activity
        step("idle", 1'b0, 1'b1, 1'b0);

        // Flush alone, then 31 not-taken -> all ones, full; 32nd dropped -> overflow
        step("fl0", 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < MAP_LEN; i++) step("fill", 1'b1, 1'b0, 1'b0);
        check("s31.full", 64'(map_o), 64'({MAP_LEN{1'b1}}));
        step("s31.drop", 1'b1, 1'b1, 1'b0);
        step("s31.sticky", 1'b0, 1'b0, 1'b0);

        // Flush alone clears overflow; build 5 then flush + valid(not-taken)
        step("fl1", 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step("five", 1'b1, 1'(i % 2), 1'b0);
        step("s32", 1'b1, 1'b0, 1'b1);
        check("s32.bit0", 64'(map_o[0]), 64'(1));

        // Count 7 then flush alone -> empty
        for (int i = 0; i < 6; i++) step("seven", 1'b1, 1'(i % 3 == 0), 1'b0);
        step("s33", 1'b0, 1'b0, 1'b1);
        check("s33.empty", 64'(empty_o), 64'(1));

        // Count 12, asynchronous reset mid-cycle
        for (int i = 0; i < 12; i++) step("twelve", 1'b1, 1'(i % 2), 1'b0);
        #2;
        rst_ni = 1'b0;
        #1;
        mq.delete();
        movf = 1'b0;
        check_outputs("s34.async", model_now());
        valid_i = 1'b1;
        taken_i = 1'b0;
        flush_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        check_outputs("s34.held", model_now());
        @(negedge clk_i);
        valid_i = 1'b0;
        flush_i = 1'b0;
        rst_ni  = 1'b1;
        step("first", 1'b1, 1'b0, 1'b0);

        // Random traffic
        for (int n = 0; n < 10000; n++) begin
            step("rand", 1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 99) < 2));
        end

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $error("FAIL leftover observed=%0d expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trdb_branch_map.md
TRDB_BRANCH_MAP -- requirements
Module: trdb_branch_map

Interface
REQ-001 SHALL have parameter MAP_LEN, default 31, the maximum number of branches held in the map.
REQ-002 SHALL have port clk_i, input, 1, the clock.
REQ-003 SHALL have port rst_ni, input, 1, the reset: asynchronous, active-low.
REQ-004 SHALL have port valid_i, input, 1, a resolved-branch event from the instruction-type detector (tc_branch_o).
REQ-005 SHALL have port taken_i, input, 1, the branch outcome (tc_branch_taken_o), sampled only when valid_i=1.
REQ-006 SHALL have port flush_i, input, 1, the packet emitter consuming the current map in this cycle.
REQ-007 SHALL have port map_o, output, MAP_LEN, the branch map; bit i holds the outcome of the (i+1)-th branch since the last flush.
REQ-008 SHALL have port branches_o, output, $clog2(MAP_LEN+1), the number of valid map bits.
REQ-009 SHALL have port full_o, output, 1, asserted when branches_o==MAP_LEN.
REQ-010 SHALL have port empty_o, output, 1, asserted when branches_o==0.
REQ-011 SHALL have port overflow_o, output, 1, a sticky flag recording that a branch was dropped.

Function
REQ-012 SHALL encode each outcome as bit=1 for not taken and bit=0 for taken.
REQ-013 SHALL fill map bits LSB-first: a branch accepted with count n writes bit n, and the count becomes n+1.
REQ-014 SHALL drive all outputs directly from registered state, with no input-to-output combinational path.
REQ-015 SHALL show an accepted branch on map_o and branches_o exactly one cycle after the valid_i edge.
REQ-016 SHALL, when flush_i=1 and valid_i=0, present the pre-flush map_o and branches_o during that cycle, then clear map, count and overflow at the edge.
REQ-017 SHALL, when flush_i=1 and valid_i=1 in the same cycle, let the flush consume the old map; the new branch becomes bit 0 with count 1, all other bits are 0, and overflow is cleared.
REQ-018 SHALL, when valid_i=1, flush_i=0 and full_o=1, drop the branch, leave the map and count unchanged, and set overflow_o=1.
REQ-019 SHALL hold overflow_o at 1 until a flush_i edge clears it.
REQ-020 SHALL hold map bits at or above branches_o at 0 at all times.
REQ-021 SHALL never let the count exceed MAP_LEN or wrap to 0 other than by flush.
REQ-022 SHALL hold all state when valid_i=0 and flush_i=0.
REQ-023 SHALL decode full_o and empty_o from the registered count, updating in the same cycle as branches_o.

Reset
REQ-024 SHALL, on rst_ni low at any time including mid-accumulation, immediately set map_o=0, branches_o=0, empty_o=1, full_o=0 and overflow_o=0.
REQ-025 SHALL ignore valid_i and flush_i while rst_ni is low.
REQ-026 SHALL accept a branch in the first cycle after reset release.

Structure
REQ-027 SHALL take BRANCH_MAP_LEN (31) and the branch-count width constant from trdb_pkg, with MAP_LEN defaulting to BRANCH_MAP_LEN.
REQ-028 SHALL be a single flat module with no sub-module, since the state is one map register, one counter and one flag.
REQ-029 SHALL place its input side directly downstream of the instruction-type detector and its output side upstream of the packet emitter.

Verification
REQ-030 SHALL cover this scenario: branches taken, not-taken, not-taken on three consecutive cycles -> map_o=3'b110, branches_o=3 one cycle after the last.
REQ-031 SHALL cover this scenario: 31 not-taken branches -> map_o=all ones, full_o=1; a 32nd branch without flush -> map unchanged, overflow_o=1.
REQ-032 SHALL cover this scenario: map of 5 branches, then flush_i and valid_i(taken=0) together -> that cycle shows count 5; next cycle count 1, map_o[0]=1, overflow_o=0.
REQ-033 SHALL cover this scenario: flush_i alone with count 7 -> next cycle map_o=0, empty_o=1.
REQ-034 SHALL cover this scenario: rst_ni asserted asynchronously with count 12 and overflow 0 -> all outputs at reset values before the next clock edge.
REQ-035 SHALL cover this scenario: random valid/taken/flush for 10k cycles against a queue model -> map_o and branches_o match every cycle, and no bit above the count is ever set.
